// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the decode stage and the instruction encoder.
package rv_isa_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_LUI  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  typedef enum logic [3:0] {
    ET_R     = 4'd0,
    ET_I     = 4'd1,
    ET_LW    = 4'd2,
    ET_SW    = 4'd3,
    ET_SB    = 4'd4,
    ET_JAL   = 4'd5,
    ET_JALR  = 4'd6,
    ET_LUI   = 4'd7,
    ET_AUIPC = 4'd8
  } enc_type_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_MEM_W   = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] alu_funct3(input logic [3:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB: return F3_ADD_SUB;
      ALU_SLL:          return F3_SLL;
      ALU_SLT:          return F3_SLT;
      ALU_SLTU:         return F3_SLTU;
      ALU_XOR:          return F3_XOR;
      ALU_SRL, ALU_SRA: return F3_SR;
      ALU_OR:           return F3_OR;
      ALU_AND:          return F3_AND;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] alu);
    return (alu == ALU_SLL) || (alu == ALU_SRL) || (alu == ALU_SRA);
  endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Places immediate bits into their RV32I instruction positions and flags
// range/alignment violations for the given instruction type.
module rv_imm_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  i_type,
  input  logic [3:0]  i_alucode,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_imm_err
);

  logic signed [31:0] w_simm;
  logic               w_fits12;
  enc_type_e          w_type;

  assign w_simm   = i_imm;
  assign w_fits12 = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
  assign w_type   = enc_type_e'(i_type);

  always_comb begin
    o_imm_bits = '0;
    o_imm_err  = 1'b0;
    case (w_type)
      ET_I: begin
        if (is_shift(i_alucode)) begin
          o_imm_bits[24:20] = i_imm[4:0];
          o_imm_err         = (w_simm < 32'sd0) || (w_simm > 32'sd31);
        end else begin
          o_imm_bits[31:20] = i_imm[11:0];
          o_imm_err         = !w_fits12;
        end
      end
      ET_LW, ET_JALR: begin
        o_imm_bits[31:20] = i_imm[11:0];
        o_imm_err         = !w_fits12;
      end
      ET_SW: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
        o_imm_err         = !w_fits12;
      end
      ET_SB: begin
        o_imm_bits[31]    = i_imm[12];
        o_imm_bits[30:25] = i_imm[10:5];
        o_imm_bits[11:8]  = i_imm[4:1];
        o_imm_bits[7]     = i_imm[11];
        o_imm_err         = i_imm[0] || (w_simm < -32'sd4096) || (w_simm > 32'sd4094);
      end
      ET_JAL: begin
        o_imm_bits[31]    = i_imm[20];
        o_imm_bits[30:21] = i_imm[10:1];
        o_imm_bits[20]    = i_imm[11];
        o_imm_bits[19:12] = i_imm[19:12];
        o_imm_err         = i_imm[0] || (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574);
      end
      ET_LUI, ET_AUIPC: begin
        o_imm_bits[31:12] = i_imm[31:12];
        o_imm_err         = |i_imm[11:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Packs decoded RV32I fields into an instruction word and writes it to IMEM
// at an auto-incrementing address; illegal requests park the FSM in ERR.
//
//  state | meaning
//  IDLE  | waiting for a request (enc_ready = ~full & ~err)
//  ENC   | captured fields are encoded and checked for legality
//  WR    | imem_we asserted for one cycle, address advances on exit
//  ERR   | illegal request seen, held until clear
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [3:0]        enc_type,
  input  logic [3:0]        enc_alucode,
  input  logic [2:0]        enc_funct3,
  input  logic [4:0]        enc_rd,
  input  logic [4:0]        enc_rs1,
  input  logic [4:0]        enc_rs2,
  input  logic [31:0]       enc_imm,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_ERR} state_e;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_e            r_state, w_next;
  logic [3:0]        r_type, r_alu;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd, r_rs1, r_rs2;
  logic [31:0]       r_imm;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we, r_err, r_full;

  logic              w_ready, w_accept;
  logic [31:0]       w_imm_bits, w_word;
  logic              w_imm_err, w_fn_err, w_illegal;
  logic [6:0]        w_opc, w_f7;
  logic [2:0]        w_f3;
  logic [4:0]        w_rd, w_rs1, w_rs2;
  enc_type_e         w_type;

  assign w_ready  = (r_state == S_IDLE) && !r_full && !r_err;
  assign w_accept = enc_valid && w_ready && !clear;
  assign w_type   = enc_type_e'(r_type);

  rv_imm_pack u_imm_pack (
    .i_type     (r_type),
    .i_alucode  (r_alu),
    .i_imm      (r_imm),
    .o_imm_bits (w_imm_bits),
    .o_imm_err  (w_imm_err)
  );

  always_comb begin
    w_opc    = '0;
    w_f3     = '0;
    w_f7     = '0;
    w_rd     = '0;
    w_rs1    = '0;
    w_rs2    = '0;
    w_fn_err = 1'b0;
    case (w_type)
      ET_R: begin
        w_opc    = OPC_R;
        w_f3     = alu_funct3(r_alu);
        w_f7     = (r_alu == ALU_SUB || r_alu == ALU_SRA) ? F7_ALT : F7_ZERO;
        {w_rd, w_rs1, w_rs2} = {r_rd, r_rs1, r_rs2};
        w_fn_err = (r_alu == ALU_LUI) || (r_alu > ALU_SLTU);
      end
      ET_I: begin
        w_opc    = OPC_I;
        w_f3     = alu_funct3(r_alu);
        w_f7     = (r_alu == ALU_SRA) ? F7_ALT : F7_ZERO;
        {w_rd, w_rs1} = {r_rd, r_rs1};
        w_fn_err = (r_alu == ALU_SUB) || (r_alu == ALU_LUI) || (r_alu > ALU_SLTU);
      end
      ET_LW: begin
        w_opc = OPC_LOAD;
        w_f3  = F3_MEM_W;
        {w_rd, w_rs1} = {r_rd, r_rs1};
      end
      ET_SW: begin
        w_opc = OPC_STORE;
        w_f3  = F3_MEM_W;
        {w_rs1, w_rs2} = {r_rs1, r_rs2};
      end
      ET_SB: begin
        w_opc    = OPC_BR;
        w_f3     = r_f3;
        {w_rs1, w_rs2} = {r_rs1, r_rs2};
        w_fn_err = (r_f3 == 3'b010) || (r_f3 == 3'b011);
      end
      ET_JAL: begin
        w_opc = OPC_JAL;
        w_rd  = r_rd;
      end
      ET_JALR: begin
        w_opc = OPC_JALR;
        w_f3  = F3_JALR;
        {w_rd, w_rs1} = {r_rd, r_rs1};
      end
      ET_LUI: begin
        w_opc = OPC_LUI;
        w_rd  = r_rd;
      end
      ET_AUIPC: begin
        w_opc = OPC_AUIPC;
        w_rd  = r_rd;
      end
      default: w_fn_err = 1'b1;
    endcase
  end

  // Unused fields are zero above, so the immediate bits can simply be OR-ed in.
  assign w_word    = w_imm_bits | {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_opc};
  assign w_illegal = w_fn_err || w_imm_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ENC;
      S_ENC:   w_next = w_illegal ? S_ERR : S_WR;
      S_WR:    w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type <= '0;
      r_alu  <= '0;
      r_f3   <= '0;
      r_rd   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_imm  <= '0;
    end else if (w_accept) begin
      r_type <= enc_type;
      r_alu  <= enc_alucode;
      r_f3   <= enc_funct3;
      r_rd   <= enc_rd;
      r_rs1  <= enc_rs1;
      r_rs2  <= enc_rs2;
      r_imm  <= enc_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= ADDR_BASE;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else if (clear) begin
      r_addr  <= ADDR_BASE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_ENC) begin
        if (w_illegal) begin
          r_err <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
        end
      end
      // The last slot is written but the address does not wrap.
      if (r_state == S_WR) begin
        if (r_addr == ADDR_LAST) r_full <= 1'b1;
        else                     r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign enc_ready  = w_ready;
  assign imem_we    = r_we && !clear;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;
  assign full       = r_full;

endmodule
